// File: rtl/fifo_qword_packer_pkg.sv
// Shared types for the fifo wide datapath: word/qword beats and packer state.
// No logic; latency and backpressure do not apply.
package fifo_qword_packer_pkg;

  localparam int WordW          = 32;
  localparam int DefaultLanes   = 4;
  localparam int DefaultTimeout = 16;

  typedef logic [WordW-1:0] word_t;

  // Lane 0 occupies the least significant word and holds the oldest entry.
  typedef word_t [DefaultLanes-1:0] qword_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  function automatic int timer_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_qword_packer_if.sv
// Narrow word stream in, packed wide beat out; slave is the packer's view.
// Pure wiring: no latency; valid/ready on both sides.
interface fifo_qword_packer_if
  import fifo_qword_packer_pkg::*;
#(
  parameter int Lanes = DefaultLanes
);

  localparam int CountW = $clog2(Lanes + 1);

  word_t                    in_data_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [WordW*Lanes-1:0]   out_data_o;
  logic [CountW-1:0]        out_count_o;
  logic                     out_last_o;
  logic                     out_valid_o;
  logic                     out_ready_i;

  modport slave (
    input  in_data_i,
    input  in_valid_i,
    output in_ready_o,
    output out_data_o,
    output out_count_o,
    output out_last_o,
    output out_valid_o,
    input  out_ready_i
  );

  modport master (
    output in_data_i,
    output in_valid_i,
    input  in_ready_o,
    input  out_data_o,
    input  out_count_o,
    input  out_last_o,
    input  out_valid_o,
    output out_ready_i
  );

endinterface

// File: rtl/fifo_qword_packer_idle_timer.sv
// Counts idle cycles and pulses expired_o on the cycle the count would reach the limit.
// Combinational pulse from a registered count; a zero limit never expires.
module fifo_idle_timer
  import fifo_qword_packer_pkg::*;
#(
  parameter  int TimeoutCycles = DefaultTimeout,
  localparam int CntW          = timer_width(TimeoutCycles)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cnt_en_i,
  input  logic            clear_i,
  input  logic [CntW-1:0] limit_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q;
  logic            at_limit;

  // Firing one count early lets the owner change state on the same edge the count lands on the limit.
  assign at_limit  = (limit_i != '0) && (cnt_q == limit_i - 1'b1);
  assign expired_o = cnt_en_i && !clear_i && at_limit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i || expired_o) begin
      cnt_q <= '0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_qword_packer.sv
// Packs Lanes consecutive words into one beat; partial beats close on flush or idle timeout.
// Full beat valid the cycle after the last word; input stalls while a beat is held.
module fifo_qword_packer
  import fifo_qword_packer_pkg::*;
#(
  parameter int Lanes         = DefaultLanes,
  parameter int TimeoutCycles = DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  fifo_qword_packer_if.slave bus
);

  localparam int CountW = $clog2(Lanes + 1);
  localparam int TimerW = timer_width(TimeoutCycles);

  packer_state_e          state_q;
  logic [CountW-1:0]      count_q;
  word_t                  lanes_q [Lanes];
  logic                   last_q;
  logic                   valid_q;

  logic                   in_ready;
  logic                   in_hs;
  logic [CountW-1:0]      count_next;
  logic                   idle_en;
  logic                   timer_clear;
  logic                   timed_out;
  logic                   close_beat;
  logic [WordW*Lanes-1:0] data_flat;

  // Ready depends only on state, so nothing from out_ready_i reaches it combinationally.
  assign in_ready   = rst_ni && (state_q == FILL);
  assign in_hs      = bus.in_valid_i && in_ready;
  assign count_next = count_q + CountW'(in_hs);

  assign idle_en     = (state_q == FILL) && (count_q != '0) && !in_hs;
  assign timer_clear = in_hs || (state_q != FILL);

  fifo_idle_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt_en_i (idle_en),
    .clear_i  (timer_clear),
    .limit_i  (TimerW'(TimeoutCycles)),
    .expired_o(timed_out)
  );

  // A flush only closes a beat that will hold at least one word, so empty beats never appear.
  assign close_beat = (state_q == FILL) &&
                      ((count_next == CountW'(Lanes)) ||
                       (flush_i && (count_next != '0)) ||
                       timed_out);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FILL;
      count_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < Lanes; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FILL: begin
          if (in_hs) begin
            for (int i = 0; i < Lanes; i++) begin
              if (count_q == CountW'(i)) begin
                lanes_q[i] <= bus.in_data_i;
              end
            end
            count_q <= count_next;
          end
          if (close_beat) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            last_q  <= flush_i;
          end
        end
        HOLD: begin
          if (flush_i) begin
            last_q <= 1'b1;
          end
          // Zeroing the lanes on release keeps unfilled lanes of the next partial beat at 0.
          if (bus.out_ready_i) begin
            state_q <= FILL;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < Lanes; i++) begin
              lanes_q[i] <= '0;
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  always_comb begin
    data_flat = '0;
    for (int i = 0; i < Lanes; i++) begin
      data_flat[WordW*i +: WordW] = lanes_q[i];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_data_o  = data_flat;
  assign bus.out_count_o = count_q;
  assign bus.out_last_o  = last_q;
  assign bus.out_valid_o = valid_q;

endmodule

// File: tb/tb_fifo_qword_packer.sv
// Directed bench for fifo_qword_packer: vector table plus timeout and reset sequences.
module tb_fifo_qword_packer;
  import fifo_qword_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic flush_nt;

  always #5 clk = ~clk;

  fifo_qword_packer_if #(.Lanes(4)) bus ();
  fifo_qword_packer_if #(.Lanes(4)) bus_nt ();

  fifo_qword_packer #(.Lanes(4), .TimeoutCycles(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  fifo_qword_packer #(.Lanes(4), .TimeoutCycles(0)) dut_nt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush_nt),
    .bus    (bus_nt)
  );

  typedef struct {
    logic       f;
    logic       v;
    word_t      d;
    logic       r;
    logic       e_irdy;
    logic       e_ovld;
    logic [2:0] e_cnt;
    logic       e_last;
    qword_t     e_dat;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic qword_t q4(input word_t l0, input word_t l1, input word_t l2, input word_t l3);
    qword_t q;
    q[0] = l0; q[1] = l1; q[2] = l2; q[3] = l3;
    return q;
  endfunction

  function automatic vec_t mk(input logic f, input logic v, input word_t d, input logic r,
                              input logic ei, input logic eo, input logic [2:0] ec,
                              input logic el, input qword_t ed);
    vec_t x;
    x.f = f; x.v = v; x.d = d; x.r = r;
    x.e_irdy = ei; x.e_ovld = eo; x.e_cnt = ec; x.e_last = el; x.e_dat = ed;
    return x;
  endfunction

  // Input row in FILL: packer ready, no beat presented.
  function automatic vec_t in_row(input logic f, input logic v, input word_t d);
    return mk(f, v, d, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, '0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input word_t d, input logic r);
    flush = f;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = r;
  endtask

  task automatic send_word(input word_t d);
    drive(1'b0, 1'b1, d, 1'b1);
    tick();
  endtask

  task automatic check_beat(input string name, input logic [2:0] cnt, input logic last, input qword_t dat);
    chk({name, "_valid"}, 128'(bus.out_valid_o), 128'(1'b1));
    chk({name, "_count"}, 128'(bus.out_count_o), 128'(cnt));
    chk({name, "_last"},  128'(bus.out_last_o),  128'(last));
    chk({name, "_data"},  128'(bus.out_data_o),  128'(dat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    qword_t b1, b2, b3, b4, b5, b6;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    flush_nt = 1'b0;
    bus_nt.in_valid_i  = 1'b0;
    bus_nt.in_data_i   = '0;
    bus_nt.out_ready_i = 1'b1;

    tick();
    tick();
    chk("rst_in_ready",  128'(bus.in_ready_o),  128'(1'b0));
    chk("rst_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
    chk("rst_out_count", 128'(bus.out_count_o), 128'(0));
    chk("rst_out_last",  128'(bus.out_last_o),  128'(1'b0));
    chk("rst_out_data",  128'(bus.out_data_o),  128'(0));
    rst_n = 1'b1;

    b1 = q4(32'h11, 32'h22, 32'h33, 32'h44);
    b2 = q4(32'hA, 32'hB, 32'h0, 32'h0);
    b3 = q4(32'h1, 32'h2, 32'hC, 32'h0);
    b4 = q4(32'h1, 32'h2, 32'h3, 32'h4);
    b5 = q4(32'h5, 32'h6, 32'h7, 32'h8);
    b6 = q4(32'h21, 32'h22, 32'h23, 32'h24);

    // Full beat at line rate
    vecs.push_back(in_row(0, 1, 32'h11));
    vecs.push_back(in_row(0, 1, 32'h22));
    vecs.push_back(in_row(0, 1, 32'h33));
    vecs.push_back(in_row(0, 1, 32'h44));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 0, b1));
    vecs.push_back(in_row(0, 0, 0));
    // Flush of a two-word partial beat, then a flush with nothing buffered
    vecs.push_back(in_row(0, 1, 32'hA));
    vecs.push_back(in_row(0, 1, 32'hB));
    vecs.push_back(in_row(1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, b2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, b2));
    vecs.push_back(in_row(1, 0, 0));
    vecs.push_back(in_row(0, 0, 0));
    vecs.push_back(in_row(0, 0, 0));
    // Flush together with the third word
    vecs.push_back(in_row(0, 1, 32'h1));
    vecs.push_back(in_row(0, 1, 32'h2));
    vecs.push_back(in_row(1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 1, b3));
    vecs.push_back(in_row(0, 0, 0));
    // Flush together with the word that fills the beat
    vecs.push_back(in_row(0, 1, 32'h1));
    vecs.push_back(in_row(0, 1, 32'h2));
    vecs.push_back(in_row(0, 1, 32'h3));
    vecs.push_back(in_row(1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 1, b4));
    vecs.push_back(in_row(0, 0, 0));
    // Flush while a beat is held sets last from the next cycle
    vecs.push_back(in_row(0, 1, 32'h5));
    vecs.push_back(in_row(0, 1, 32'h6));
    vecs.push_back(in_row(0, 1, 32'h7));
    vecs.push_back(in_row(0, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, b5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, b5));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 1, b5));
    vecs.push_back(in_row(0, 0, 0));
    // Consumer stalls for five cycles with a word waiting upstream
    vecs.push_back(in_row(0, 1, 32'h21));
    vecs.push_back(in_row(0, 1, 32'h22));
    vecs.push_back(in_row(0, 1, 32'h23));
    vecs.push_back(in_row(0, 1, 32'h24));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 1, 32'h99, 0, 0, 1, 4, 0, b6));
    vecs.push_back(mk(0, 1, 32'h99, 1, 0, 1, 4, 0, b6));
    vecs.push_back(in_row(0, 1, 32'h99));
    vecs.push_back(in_row(1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, q4(32'h99, 0, 0, 0)));
    vecs.push_back(in_row(0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r);
      #1;
      chk($sformatf("vec%0d_in_ready", i),  128'(bus.in_ready_o),  128'(vecs[i].e_irdy));
      chk($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid_o), 128'(vecs[i].e_ovld));
      if (vecs[i].e_ovld) begin
        chk($sformatf("vec%0d_count", i), 128'(bus.out_count_o), 128'(vecs[i].e_cnt));
        chk($sformatf("vec%0d_last", i),  128'(bus.out_last_o),  128'(vecs[i].e_last));
        chk($sformatf("vec%0d_data", i),  128'(bus.out_data_o),  128'(vecs[i].e_dat));
      end
      @(posedge clk);
      #1;
    end

    // Idle timeout: word at cycle 0, beat visible on cycle 17
    send_word(32'hD);
    drive(1'b0, 1'b0, '0, 1'b1);
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      seen |= bus.out_valid_o;
      tick();
    end
    chk("timeout_early", 128'(seen), 128'(1'b0));
    check_beat("timeout", 3'd1, 1'b0, q4(32'hD, 0, 0, 0));
    tick();
    chk("timeout_release", 128'(bus.in_ready_o), 128'(1'b1));

    // Flush on the expiring cycle wins and marks last
    send_word(32'hE);
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int k = 1; k <= 15; k++) tick();
    chk("tmo_flush_pre", 128'(bus.out_valid_o), 128'(1'b0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_beat("tmo_flush", 3'd1, 1'b1, q4(32'hE, 0, 0, 0));
    tick();

    // Timeout disabled: a lone word stays buffered
    bus_nt.in_valid_i = 1'b1;
    bus_nt.in_data_i  = 32'h5;
    tick();
    bus_nt.in_valid_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      seen |= bus_nt.out_valid_o;
      tick();
    end
    chk("no_timeout_beat", 128'(seen), 128'(1'b0));
    flush_nt = 1'b1;
    tick();
    flush_nt = 1'b0;
    chk("no_timeout_flush_valid", 128'(bus_nt.out_valid_o), 128'(1'b1));
    chk("no_timeout_flush_count", 128'(bus_nt.out_count_o), 128'(1));
    chk("no_timeout_flush_data",  128'(bus_nt.out_data_o),  128'(q4(32'h5, 0, 0, 0)));
    tick();

    // Reset with three words buffered discards them
    send_word(32'h31);
    send_word(32'h32);
    send_word(32'h33);
    drive(1'b0, 1'b0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 128'(bus.in_ready_o),  128'(1'b1));
    chk("midrst_release_valid", 128'(bus.out_valid_o), 128'(1'b0));
    send_word(32'h41);
    send_word(32'h42);
    send_word(32'h43);
    send_word(32'h44);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_beat("midrst_beat", 3'd4, 1'b0, q4(32'h41, 32'h42, 32'h43, 32'h44));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
